// File: rtl/psum_drain.sv
// psum_drain: pops full psum rows from the PE-array output FIFO into the psum SRAM.
// Define PSUM_DRAIN_RELU_EN to clamp negative lanes to zero while a row is captured.
module psum_drain #(
  parameter int col    = 8,
  parameter int bw     = 16,
  parameter int addr_w = 11,
  parameter int cnt_w  = 11,
  parameter int rd_lat = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [addr_w-1:0]   base_addr,
  input  logic [cnt_w-1:0]    num_rows,
  input  logic                fifo_valid,
  input  logic [col*bw-1:0]   fifo_out,
  output logic                fifo_rd,
  output logic                mem_cen,
  output logic                mem_wen,
  output logic [addr_w-1:0]   mem_addr,
  output logic [col*bw-1:0]   mem_d,
  output logic                busy,
  output logic [cnt_w-1:0]    row_cnt,
  output logic                done
);

  localparam int lat_w = $clog2(rd_lat + 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    WRITE,
    DONE
  } state_t;

  state_t              state;
  state_t              nxt;
  logic [lat_w-1:0]    cnt;
  logic [addr_w-1:0]   addr;
  logic [cnt_w-1:0]    rows;
  logic                pop;
  logic                cap;
  logic                inc;
  logic                acc;
  logic                last;

  function automatic logic [col*bw-1:0] clamp(
    input logic [col*bw-1:0] r
  );
    logic [col*bw-1:0] o;
    o = r;
`ifdef PSUM_DRAIN_RELU_EN
    for (int i = 0; i < col; i++) begin
      if (r[bw*i+bw-1]) begin
        o[bw*i +: bw] = '0;
      end
    end
`endif
    return o;
  endfunction

  assign last = (row_cnt + cnt_w'(1)) == rows;

  always_comb begin
    nxt = state;
    pop = 1'b0;
    cap = 1'b0;
    inc = 1'b0;
    acc = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          acc = 1'b1;
          nxt = (num_rows == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (fifo_valid) begin
          pop = 1'b1;
          nxt = WAIT;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          cap = 1'b1;
          nxt = WRITE;
        end
      end
      WRITE: begin
        inc = 1'b1;
        // next pop is issued straight from WRITE to keep one row per rd_lat+2
        if (last) begin
          nxt = DONE;
        end else if (fifo_valid) begin
          pop = 1'b1;
          nxt = WAIT;
        end else begin
          nxt = ISSUE;
        end
      end
      DONE: begin
        nxt = IDLE;
      end
      default: begin
        nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      fifo_rd <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= nxt;
      fifo_rd <= pop;
      done    <= (state == DONE);
      // stays high through the cycle that shows the done pulse
      busy    <= (state != IDLE) || (nxt != IDLE);
      if (pop) begin
        cnt <= lat_w'(rd_lat);
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - lat_w'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr     <= '0;
      rows     <= '0;
      row_cnt  <= '0;
      mem_cen  <= 1'b1;
      mem_wen  <= 1'b1;
      mem_addr <= '0;
      mem_d    <= '0;
    end else begin
      mem_cen <= !cap;
      mem_wen <= !cap;
      if (cap) begin
        mem_addr <= addr;
        mem_d    <= clamp(fifo_out);
      end
      if (acc) begin
        addr    <= base_addr;
        rows    <= num_rows;
        row_cnt <= '0;
      end else if (inc) begin
        addr    <= addr + addr_w'(1);
        row_cnt <= row_cnt + cnt_w'(1);
      end
    end
  end

endmodule
